// File: rtl/retire_map_pkg.sv
// Shared definitions for the retirement map table.
// Holds the widths derived from the default configuration, the arch-index and
// physical-tag typedefs, and the restore FSM state encoding.
// Build option: ZERO_REG_HARDWIRE_EN pins arch register 0 to physical tag 0.
package retire_map_pkg;

  localparam int DEF_ARCH_REGS = 32;
  localparam int DEF_PREGS     = 64;
  localparam int DEF_RETIRE_W  = 2;
  localparam int DEF_RESTORE_W = 8;

  // $clog2 clamped to at least one bit, so single-entry ranges still get a port.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_AW = $clog2(DEF_ARCH_REGS);
  localparam int DEF_PW = $clog2(DEF_PREGS);
  localparam int DEF_IW = clog2_min1(DEF_RETIRE_W);

  typedef logic [DEF_AW-1:0] arch_idx_t;
  typedef logic [DEF_PW-1:0] preg_tag_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESTORE = 1'b1
  } restore_state_t;

endpackage

// File: rtl/retire_map_table_merge.sv
// retire_commit_merge: combinational per-slot commit resolution.
// Decides which retire slots commit (slots above a mispredicted branch are
// squashed), which of them write the map, and for each writing slot whether a
// lower writing slot in the same group already targets the same arch register.
// In that case the displaced tag is that lower slot's new tag rather than the
// table entry, so every allocated tag is freed exactly once.
// Ports:
//   retire_valid_i / retire_has_dest_i / retire_arch_i / retire_tag_i : retire group
//   recover_i / recover_idx_i : mispredicted branch and its slot
//   write_en_o : slot writes the table
//   fwd_hit_o / fwd_tag_o : nearest lower same-arch writer and its tag
// Build option: ZERO_REG_HARDWIRE_EN drops every write to arch register 0.
module retire_commit_merge #(
  parameter int RETIRE_W = 2,
  parameter int AW       = 5,
  parameter int PW       = 6,
  parameter int IW       = 1
) (
  input  logic [RETIRE_W-1:0]         retire_valid_i,
  input  logic [RETIRE_W-1:0]         retire_has_dest_i,
  input  logic [RETIRE_W-1:0][AW-1:0] retire_arch_i,
  input  logic [RETIRE_W-1:0][PW-1:0] retire_tag_i,
  input  logic                        recover_i,
  input  logic [IW-1:0]               recover_idx_i,
  output logic [RETIRE_W-1:0]         write_en_o,
  output logic [RETIRE_W-1:0]         fwd_hit_o,
  output logic [RETIRE_W-1:0][PW-1:0] fwd_tag_o
);

  logic squash;
  logic commit;

  always_comb begin
    write_en_o = '0;
    fwd_hit_o  = '0;
    fwd_tag_o  = '0;
    squash     = 1'b0;
    commit     = 1'b0;
    for (int i = 0; i < RETIRE_W; i++) begin
      // With a single retire port nothing can sit above the branch.
      squash = (RETIRE_W > 1) && recover_i && (IW'(i) > recover_idx_i);
      commit = retire_valid_i[i] && !squash;
`ifdef ZERO_REG_HARDWIRE_EN
      write_en_o[i] = commit && retire_has_dest_i[i] && (retire_arch_i[i] != '0);
`else
      write_en_o[i] = commit && retire_has_dest_i[i];
`endif
      // Ascending scan: the last match is the nearest lower writer.
      for (int j = 0; j < i; j++) begin
        if (write_en_o[j] && (retire_arch_i[j] == retire_arch_i[i])) begin
          fwd_hit_o[i] = 1'b1;
          fwd_tag_o[i] = retire_tag_i[j];
        end
      end
    end
  end

endmodule

// File: rtl/retire_map_table.sv
// retire_map_table: architectural (retirement) register map.
// Commits up to RETIRE_W retiring destinations per cycle, returns each
// displaced physical tag one cycle later, and on a branch recovery streams the
// committed map back to the speculative map RESTORE_W entries per cycle.
// Ports:
//   clk, reset (synchronous, active-high)
//   retire_valid_i, retire_has_dest_i, retire_arch_i, retire_tag_i : retire group
//   recover_i, recover_idx_i : mispredicted branch in this group and its slot
//   freed_valid_o, freed_tag_o : registered displaced tags
//   restore_valid_o, restore_base_o, restore_tag_o : restore chunk stream
//   busy_o : restore walk in progress, retirement must stall
// Build option: ZERO_REG_HARDWIRE_EN keeps arch register 0 fixed at tag 0.
//
// state      | meaning
// ST_IDLE    | normal retirement, no restore output
// ST_RESTORE | emitting chunk cnt_q of the committed map
module retire_map_table
  import retire_map_pkg::*;
#(
  parameter int ARCH_REGS = 32,
  parameter int PREGS     = 64,
  parameter int RETIRE_W  = 2,
  parameter int RESTORE_W = 8,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PREGS),
  localparam int IW = clog2_min1(RETIRE_W)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [RETIRE_W-1:0]          retire_valid_i,
  input  logic [RETIRE_W-1:0]          retire_has_dest_i,
  input  logic [RETIRE_W-1:0][AW-1:0]  retire_arch_i,
  input  logic [RETIRE_W-1:0][PW-1:0]  retire_tag_i,
  input  logic                         recover_i,
  input  logic [IW-1:0]                recover_idx_i,
  output logic [RETIRE_W-1:0]          freed_valid_o,
  output logic [RETIRE_W-1:0][PW-1:0]  freed_tag_o,
  output logic                         restore_valid_o,
  output logic [AW-1:0]                restore_base_o,
  output logic [RESTORE_W-1:0][PW-1:0] restore_tag_o,
  output logic                         busy_o
);

  localparam int K  = ARCH_REGS / RESTORE_W;
  localparam int CW = clog2_min1(K);

  if (ARCH_REGS % RESTORE_W != 0) begin : g_bad_restore_w
    $error("retire_map_table: ARCH_REGS must be a multiple of RESTORE_W");
  end
  if (PREGS < ARCH_REGS) begin : g_bad_pregs
    $error("retire_map_table: PREGS must be at least ARCH_REGS");
  end

  logic [PW-1:0]               map_q [ARCH_REGS];
  logic [RETIRE_W-1:0]         write_en;
  logic [RETIRE_W-1:0]         fwd_hit;
  logic [RETIRE_W-1:0][PW-1:0] fwd_tag;
  logic [RETIRE_W-1:0][PW-1:0] displaced;
  logic [RETIRE_W-1:0]         freed_valid_q;
  logic [RETIRE_W-1:0][PW-1:0] freed_tag_q;
  restore_state_t              state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  retire_commit_merge #(
    .RETIRE_W (RETIRE_W),
    .AW       (AW),
    .PW       (PW),
    .IW       (IW)
  ) u_merge (
    .retire_valid_i    (retire_valid_i),
    .retire_has_dest_i (retire_has_dest_i),
    .retire_arch_i     (retire_arch_i),
    .retire_tag_i      (retire_tag_i),
    .recover_i         (recover_i),
    .recover_idx_i     (recover_idx_i),
    .write_en_o        (write_en),
    .fwd_hit_o         (fwd_hit),
    .fwd_tag_o         (fwd_tag)
  );

  // Later slots are applied last, so the highest writer of an arch reg wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
    end else begin
      for (int s = 0; s < RETIRE_W; s++) begin
        if (write_en[s]) map_q[retire_arch_i[s]] <= retire_tag_i[s];
      end
    end
  end

  always_comb begin
    displaced = '0;
    for (int s = 0; s < RETIRE_W; s++) begin
      displaced[s] = fwd_hit[s] ? fwd_tag[s] : map_q[retire_arch_i[s]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freed_valid_q <= '0;
      freed_tag_q   <= '0;
    end else begin
      freed_valid_q <= write_en;
      for (int s = 0; s < RETIRE_W; s++) begin
        freed_tag_q[s] <= write_en[s] ? displaced[s] : '0;
      end
    end
  end

  assign freed_valid_o = freed_valid_q;
  assign freed_tag_o   = freed_tag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (recover_i) begin
          state_d = ST_RESTORE;
          cnt_d   = '0;
        end
      end
      ST_RESTORE: begin
        // A second recovery restarts the walk from chunk 0.
        if (recover_i) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(K - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    restore_valid_o = (state_q == ST_RESTORE);
    busy_o          = (state_q == ST_RESTORE);
    restore_base_o  = '0;
    restore_tag_o   = '0;
    if (restore_valid_o) begin
      restore_base_o = AW'(int'(cnt_q) * RESTORE_W);
      for (int j = 0; j < RESTORE_W; j++) begin
        restore_tag_o[j] = map_q[AW'(int'(cnt_q) * RESTORE_W + j)];
      end
`ifdef ZERO_REG_HARDWIRE_EN
      if (cnt_q == '0) restore_tag_o[0] = '0;
`endif
    end
  end

  retire_during_restore_a : assert property (
    @(posedge clk) disable iff (reset) !(busy_o && (|retire_valid_i))
  );

endmodule
